// File: rtl/ctlr_pad_responder.sv
// Two 4021-style NES joypads answering the console latch/pulse port.
// Optional turbo on A/B: define CTLR_TURBO_EN.
module ctlr_pad_responder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TURBO_PERIOD    = 833333
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] buttons_p1,
  input  logic [7:0] buttons_p2,
  input  logic       ctlr_latch,
  input  logic       ctlr_pulse_p1,
  input  logic       ctlr_pulse_p2,
`ifdef CTLR_TURBO_EN
  input  logic [1:0] turbo_p1,
  input  logic [1:0] turbo_p2,
`endif
  output logic       ctlr_data_p1,
  output logic       ctlr_data_p2,
  output logic       poll_strobe
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);

  // bit 0 latch, bit 1 pulse P1, bit 2 pulse P2
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0] hist_q;
  logic [2:0] sync_s;
  logic       latch_s;
  logic [1:0] rise;
  logic       latch_fall;

  assign sync_s     = sync_q[SYNC_STAGES-1];
  assign latch_s    = sync_s[0];
  assign rise       = sync_s[2:1] & ~hist_q[2:1];
  assign latch_fall = hist_q[0] & ~sync_s[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q[0] <= {ctlr_pulse_p2, ctlr_pulse_p1,
                    ctlr_latch};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      hist_q <= sync_s;
    end
  end

  logic [DW-1:0] db_cnt_q;
  logic [15:0]   samp_q;
  logic [15:0]   deb_q;
  logic [15:0]   raw;
  logic [15:0]   agree;
  logic          db_wrap;

  assign raw     = {buttons_p2, buttons_p1};
  assign agree   = ~(raw ^ samp_q);
  assign db_wrap = (db_cnt_q == DB_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt_q <= '0;
      samp_q   <= '0;
      deb_q    <= '0;
    end else begin
      db_cnt_q <= db_wrap ? '0 : db_cnt_q + 1'b1;
      if (db_wrap) begin
        samp_q <= raw;
        deb_q  <= (raw & agree) | (deb_q & ~agree);
      end
    end
  end

  logic [1:0][7:0] eff;

`ifdef CTLR_TURBO_EN
  localparam int TW = $clog2(TURBO_PERIOD);
  localparam logic [TW-1:0] TP_LAST =
    TW'(TURBO_PERIOD - 1);

  logic [TW-1:0] tmr_q;
  logic          tog_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q <= '0;
      tog_q <= 1'b0;
    end else if (tmr_q == TP_LAST) begin
      tmr_q <= '0;
      tog_q <= ~tog_q;
    end else begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  assign eff[0] = {deb_q[7:2],
    deb_q[1:0] & (~turbo_p1 | {2{tog_q}})};
  assign eff[1] = {deb_q[15:10],
    deb_q[9:8] & (~turbo_p2 | {2{tog_q}})};
`else
  assign eff[0] = deb_q[7:0];
  assign eff[1] = deb_q[15:8];
`endif

  logic [1:0][7:0] sr_q, sr_d;
  logic [1:0][3:0] cnt_q, cnt_d;
  logic [1:0]      data_q, data_d;

  // load dominates; count saturates at 8 so fill stays 0
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    for (int p = 0; p < 2; p++) begin
      if (latch_s) begin
        sr_d[p]  = eff[p];
        cnt_d[p] = 4'd0;
      end else if (rise[p]) begin
        sr_d[p] = {1'b0, sr_q[p][7:1]};
        if (cnt_q[p] != 4'd8)
          cnt_d[p] = cnt_q[p] + 4'd1;
      end
      data_d[p] = (cnt_q[p] < 4'd8) ?
                  ~sr_q[p][0] : 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      data_q      <= 2'b11;
      poll_strobe <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      poll_strobe <= latch_fall;
    end
  end

  assign ctlr_data_p1 = data_q[0];
  assign ctlr_data_p2 = data_q[1];

endmodule

// File: tb/tb_ctlr_pad_responder.sv
// Bench for ctlr_pad_responder: directed protocol steps
// plus random button scans against a pad reference model.
module tb_ctlr_pad_responder;

  localparam int DBP = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] buttons_p1 = 8'h00;
  logic [7:0] buttons_p2 = 8'h00;
  logic       ctlr_latch = 1'b0;
  logic       ctlr_pulse_p1 = 1'b1;
  logic       ctlr_pulse_p2 = 1'b1;
  logic       ctlr_data_p1;
  logic       ctlr_data_p2;
  logic       poll_strobe;
`ifdef CTLR_TURBO_EN
  logic [1:0] turbo_p1 = 2'b00;
  logic [1:0] turbo_p2 = 2'b00;
`endif

  int checks = 0;
  int errors = 0;

  ctlr_pad_responder #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(DBP),
    .TURBO_PERIOD(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .buttons_p1(buttons_p1),
    .buttons_p2(buttons_p2),
    .ctlr_latch(ctlr_latch),
    .ctlr_pulse_p1(ctlr_pulse_p1),
    .ctlr_pulse_p2(ctlr_pulse_p2),
`ifdef CTLR_TURBO_EN
    .turbo_p1(turbo_p1),
    .turbo_p2(turbo_p2),
`endif
    .ctlr_data_p1(ctlr_data_p1),
    .ctlr_data_p2(ctlr_data_p2),
    .poll_strobe(poll_strobe)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h",
             tag, obs, exp);
    end
  endtask

  // buttons must be held long enough to debounce
  task automatic hold();
    tick(4 * DBP);
  endtask

  task automatic do_latch(input string tag);
    int ns;
    ns = 0;
    ctlr_latch = 1'b1;
    repeat (6) begin
      tick(1);
      if (poll_strobe) ns++;
    end
    ctlr_latch = 1'b0;
    repeat (6) begin
      tick(1);
      if (poll_strobe) ns++;
    end
    chk({tag, "_strobe"}, ns, 1);
  endtask

  task automatic pulse(input logic [1:0] who);
    if (who[0]) ctlr_pulse_p1 = 1'b0;
    if (who[1]) ctlr_pulse_p2 = 1'b0;
    tick(3);
    ctlr_pulse_p1 = 1'b1;
    ctlr_pulse_p2 = 1'b1;
    tick(6);
  endtask

  // wire value of read i: active-low button, 0 after 8
  function automatic logic wire_of(
    input logic [7:0] b, input int i);
    if (i >= 8) return 1'b0;
    return ~b[i];
  endfunction

  task automatic scan(input logic [1:0] who,
                      input logic [7:0] e1,
                      input logic [7:0] e2,
                      input int first,
                      input int n,
                      input string tag);
    for (int i = first; i < n; i++) begin
      if (who[0])
        chk($sformatf("%s_p1_r%0d", tag, i),
            ctlr_data_p1, wire_of(e1, i));
      if (who[1])
        chk($sformatf("%s_p2_r%0d", tag, i),
            ctlr_data_p2, wire_of(e2, i));
      pulse(who);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r1, r2;
    logic       prev;

    tick(3);
    reset_n = 1'b1;
    tick(10);
    chk("rst_d1", ctlr_data_p1, 1);
    chk("rst_d2", ctlr_data_p2, 1);
    chk("rst_ps", poll_strobe, 0);

    buttons_p1 = 8'h09;
    hold();
    do_latch("a_start");
    chk("lat_a", ctlr_data_p1, 0);
    ctlr_pulse_p1 = 1'b0;
    tick(3);
    ctlr_pulse_p1 = 1'b1;
    tick(3);
    chk("lat_hold", ctlr_data_p1, 0);
    tick(1);
    chk("lat_upd", ctlr_data_p1, 1);
    tick(5);
    scan(2'b01, 8'h09, 8'h00, 1, 10, "as");

    buttons_p2 = 8'h80;
    hold();
    buttons_p2 = 8'h81;
    tick(DBP);
    buttons_p2 = 8'h80;
    hold();
    do_latch("glitch");
    scan(2'b10, 8'h00, 8'h80, 0, 9, "gl");

    buttons_p1 = 8'hFE;
    hold();
    ctlr_latch = 1'b1;
    tick(6);
    for (int k = 0; k < 3; k++) begin
      pulse(2'b01);
      chk($sformatf("lh_%0d", k), ctlr_data_p1, 1);
      chk($sformatf("lh_ps%0d", k), poll_strobe, 0);
    end
    begin
      int ns;
      ns = 0;
      ctlr_latch = 1'b0;
      repeat (8) begin
        tick(1);
        if (poll_strobe) ns++;
      end
      chk("lh_strobe", ns, 1);
    end
    scan(2'b01, 8'hFE, 8'h00, 0, 9, "lh");

    buttons_p1 = 8'h5A;
    hold();
    do_latch("mid");
    scan(2'b01, 8'h5A, 8'h00, 0, 3, "mid");
    reset_n = 1'b0;
    #1;
    chk("mrst_d1", ctlr_data_p1, 1);
    chk("mrst_d2", ctlr_data_p2, 1);
    chk("mrst_ps", poll_strobe, 0);
    tick(2);
    reset_n = 1'b1;
    hold();
    do_latch("after");
    scan(2'b01, 8'h5A, 8'h00, 0, 10, "aft");

    for (int r = 0; r < 6; r++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      buttons_p1 = r1;
      buttons_p2 = r2;
      hold();
      do_latch($sformatf("rnd%0d", r));
      scan(2'b11, r1, r2, 0, 10,
           $sformatf("rnd%0d", r));
    end

`ifdef CTLR_TURBO_EN
    buttons_p1 = 8'h01;
    turbo_p1 = 2'b00;
    hold();
    ctlr_latch = 1'b1;
    tick(6);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tb_off%0d", k), ctlr_data_p1, 0);
      tick(4);
    end
    turbo_p1 = 2'b01;
    tick(8);
    prev = ctlr_data_p1;
    for (int k = 0; k < 5; k++) begin
      tick(4);
      chk($sformatf("turbo%0d", k),
          ctlr_data_p1, ~prev);
      prev = ctlr_data_p1;
    end
    ctlr_latch = 1'b0;
    turbo_p1 = 2'b00;
    tick(10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
